// File: rtl/tp_pingpong_ctrl.sv
// Ping-pong write scheduler for two 8x8 transpose banks. It also merges the
// two banks' column outputs into one registered stream and flags schedule violations.
module tp_pingpong_ctrl #(
    parameter int BW = 12,
    parameter int CW = 16
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_tp_rst_n,
    output logic [8*BW-1:0] o_tp0_data,
    output logic [8*BW-1:0] o_tp1_data,
    output logic            o_tp0_en,
    output logic            o_tp1_en,
    input  logic [8*BW-1:0] i_tp0_data,
    input  logic [8*BW-1:0] i_tp1_data,
    input  logic            i_tp0_en,
    input  logic            i_tp1_en,
    output logic [8*BW-1:0] o_data,
    output logic            o_en,
    output logic [CW-1:0]   o_blk_cnt,
    output logic            o_err
);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} bank_state_t;

    bank_state_t     state_q [2];
    bank_state_t     state_d [2];
    logic [2:0]      cnt_q [2];
    logic [2:0]      cnt_d [2];
    logic            wsel_q;
    logic            wsel_d;
    logic            accept;
    logic [1:0]      exp_en_q;
    logic [2:0]      rcnt_q;
    logic [8*BW-1:0] merge_data;
    logic            violation;

    assign o_tp_rst_n = ~i_Reset;
    assign o_tp0_data = i_data;
    assign o_tp1_data = i_data;

    always_comb begin
        o_ready  = ~i_Reset & (state_q[wsel_q] == FILL);
        accept   = i_valid & o_ready;
        o_tp0_en = accept & ~wsel_q;
        o_tp1_en = accept & wsel_q;
        wsel_d   = wsel_q;
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            // A draining bank runs its 8 cycles unconditionally; the counter
            // wraps back to 0 so the bank re-enters FILL with wcnt=0.
            if (state_q[b] == DRAIN) begin
                cnt_d[b] = cnt_q[b] + 3'd1;
                if (cnt_q[b] == 3'd7) begin
                    state_d[b] = FILL;
                end
            end else if (accept && (wsel_q == 1'(b))) begin
                cnt_d[b] = cnt_q[b] + 3'd1;
                if (cnt_q[b] == 3'd7) begin
                    state_d[b] = DRAIN;
                    wsel_d     = ~wsel_q;
                end
            end
        end
    end

    always_comb begin
        merge_data = '0;
        if (i_tp0_en) begin
            merge_data = i_tp0_data;
        end else if (i_tp1_en) begin
            merge_data = i_tp1_data;
        end
        violation = (i_tp0_en != exp_en_q[0]) | (i_tp1_en != exp_en_q[1]) |
                    (i_tp0_en & i_tp1_en);
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            state_q <= '{FILL, FILL};
            cnt_q   <= '{3'd0, 3'd0};
            wsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wsel_q  <= wsel_d;
        end
    end

    // A bank's column valid is registered, so it trails its DRAIN state by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            o_en      <= 1'b0;
            o_data    <= '0;
            rcnt_q    <= 3'd0;
            o_blk_cnt <= '0;
            exp_en_q  <= 2'b00;
            o_err     <= 1'b0;
        end else begin
            o_en     <= i_tp0_en | i_tp1_en;
            o_data   <= merge_data;
            exp_en_q <= {state_q[1] == DRAIN, state_q[0] == DRAIN};
            if (o_en) begin
                rcnt_q <= rcnt_q + 3'd1;
                if (rcnt_q == 3'd7) begin
                    o_blk_cnt <= o_blk_cnt + CW'(1);
                end
            end
            if (violation) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tp_pingpong_ctrl.sv
// Testbench for tp_pingpong_ctrl. It contains behavioural transpose banks and a
// block-level reference model of the expected column stream.
module tb_tp_pingpong_ctrl;

    localparam int BW   = 12;
    localparam int CW   = 16;
    localparam int DW   = 8 * BW;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          i_Reset;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          o_tp_rst_n;
    logic [DW-1:0] o_tp0_data;
    logic [DW-1:0] o_tp1_data;
    logic          o_tp0_en;
    logic          o_tp1_en;
    logic [DW-1:0] i_tp0_data;
    logic [DW-1:0] i_tp1_data;
    logic          i_tp0_en;
    logic          i_tp1_en;
    logic [DW-1:0] o_data;
    logic          o_en;
    logic [CW-1:0] o_blk_cnt;
    logic          o_err;
    logic          force_tp1;

    always #5 clk = ~clk;

    tp_pingpong_ctrl #(.BW(BW), .CW(CW)) dut (
        .i_clk(clk), .i_Reset(i_Reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tp_rst_n(o_tp_rst_n),
        .o_tp0_data(o_tp0_data), .o_tp1_data(o_tp1_data),
        .o_tp0_en(o_tp0_en), .o_tp1_en(o_tp1_en),
        .i_tp0_data(i_tp0_data), .i_tp1_data(i_tp1_data),
        .i_tp0_en(i_tp0_en), .i_tp1_en(i_tp1_en),
        .o_data(o_data), .o_en(o_en), .o_blk_cnt(o_blk_cnt), .o_err(o_err)
    );

    // Behavioural transpose banks: 8 writes fill the bank, then it drains
    // column k on drain cycle k, and its registered column valid lags by one cycle.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic [DW-1:0] rows [8];
        logic [2:0]    wc = 3'd0;
        logic [2:0]    dc = 3'd0;
        bit            drain = 1'b0;
        logic [DW-1:0] col;
        logic [DW-1:0] out = '0;
        logic          en = 1'b0;
        logic          wen;
        int            corrupt = 0;

        assign wen = (g == 0) ? o_tp0_en : o_tp1_en;

        always_comb begin
            col = '0;
            for (int j = 0; j < 8; j++) begin
                col[(7-j)*BW +: BW] = rows[j][(7-int'(dc))*BW +: BW];
            end
        end

        always @(posedge clk) begin
            if (!o_tp_rst_n) begin
                wc    <= 3'd0;
                dc    <= 3'd0;
                drain <= 1'b0;
                en    <= 1'b0;
                out   <= '0;
            end else begin
                if (drain) begin
                    out <= col;
                    en  <= 1'b1;
                    dc  <= dc + 3'd1;
                    if (dc == 3'd7) begin
                        drain <= 1'b0;
                        wc    <= 3'd0;
                    end
                end else begin
                    en <= 1'b0;
                end
                if (wen === 1'b1) begin
                    if (drain) begin
                        corrupt <= corrupt + 1;
                    end else begin
                        rows[wc] <= i_data;
                        if (wc == 3'd7) begin
                            drain <= 1'b1;
                            dc    <= 3'd0;
                        end else begin
                            wc <= wc + 3'd1;
                        end
                    end
                end
            end
        end
    end

    assign i_tp0_data = g_bank[0].out;
    assign i_tp0_en   = g_bank[0].en;
    assign i_tp1_data = g_bank[1].out;
    assign i_tp1_en   = g_bank[1].en | force_tp1;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic          exp_tp0_en;
        logic          exp_tp1_en;
        logic          exp_en;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          vecs [20];
    int            checks = 0;
    int            failures = 0;
    int            cyc;
    int            n_acc;
    int            blocks_done;
    int            emitted;
    int            last_done [2];
    bit            exp_en_at [MAXC];
    logic [DW-1:0] exp_data_at [MAXC];
    logic [DW-1:0] cur_rows [8];
    int            first_acc_cyc;
    int            first_en_cyc;
    int            first_done_cyc;
    int            last_en_cyc;
    int            en_cycles;
    int            done_bits;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] rowWord(input int r);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[(7-k)*BW +: BW] = BW'(8*r + k);
        return w;
    endfunction

    function automatic logic [DW-1:0] colWord(input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[(7-j)*BW +: BW] = BW'(8*j + k);
        return w;
    endfunction

    task automatic modelReset();
        n_acc          = 0;
        blocks_done    = 0;
        emitted        = 0;
        last_done[0]   = -100;
        last_done[1]   = -100;
        first_acc_cyc  = -1;
        first_en_cyc   = -1;
        first_done_cyc = -1;
        last_en_cyc    = -1;
        en_cycles      = 0;
        done_bits      = 0;
        for (int i = 0; i < MAXC; i++) exp_en_at[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the block-level model,
    // then advance the model (completed blocks schedule their 8 columns).
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
        int            bank;
        bit            exp_ready;
        bit            acc;
        logic [DW-1:0] col;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        #1;
        bank      = blocks_done % 2;
        exp_ready = (cyc > last_done[bank] + 8);
        acc       = v && exp_ready;
        checkOutput("ready", o_ready, exp_ready);
        checkOutput("tp0_en", o_tp0_en, acc && bank == 0);
        checkOutput("tp1_en", o_tp1_en, acc && bank == 1);
        checkOutput("tp_data", o_tp1_data, d);
        checkOutput("tp_rst_n", o_tp_rst_n, 1'b1);
        checkOutput("o_en", o_en, exp_en_at[cyc]);
        checkOutput("o_data", o_data, exp_en_at[cyc] ? exp_data_at[cyc] : {DW{1'b0}});
        checkOutput("blk_cnt", o_blk_cnt, (emitted / 8) % 65536);
        checkOutput("err", o_err, 1'b0);
        if (o_en === 1'b1) begin
            if (first_en_cyc < 0) first_en_cyc = cyc;
            last_en_cyc = cyc;
            en_cycles++;
        end
        if (exp_en_at[cyc]) emitted++;
        if (acc) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            cur_rows[n_acc % 8] = d;
            n_acc++;
            if (n_acc % 8 == 0) begin
                for (int k = 0; k < 8; k++) begin
                    col = '0;
                    for (int j = 0; j < 8; j++) col[(7-j)*BW +: BW] = cur_rows[j][(7-k)*BW +: BW];
                    exp_en_at[cyc + 3 + k]   = 1'b1;
                    exp_data_at[cyc + 3 + k] = col;
                end
                if (first_done_cyc < 0) first_done_cyc = cyc;
                done_bits = (done_bits << 1) | int'(o_tp1_en);
                last_done[bank] = cyc;
                blocks_done++;
            end
        end
        cyc++;
    endtask

    task automatic runValid(input logic v, input int count);
        for (int i = 0; i < count; i++) applyStimulus(v, {$urandom, $urandom, $urandom});
    endtask

    task automatic doReset();
        @(negedge clk);
        i_Reset   = 1'b1;
        i_valid   = 1'b1;
        force_tp1 = 1'b0;
        #1;
        checkOutput("rst_ready", o_ready, 1'b0);
        checkOutput("rst_tp_rst_n", o_tp_rst_n, 1'b0);
        checkOutput("rst_tp0_en", o_tp0_en, 1'b0);
        checkOutput("rst_tp1_en", o_tp1_en, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_o_en", o_en, 1'b0);
        checkOutput("rst_o_data", o_data, {DW{1'b0}});
        checkOutput("rst_blk_cnt", o_blk_cnt, 0);
        checkOutput("rst_err", o_err, 1'b0);
        i_valid = 1'b0;
        i_Reset = 1'b0;
        cyc += 2;
        modelReset();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_Reset   = 1'b1;
        i_valid   = 1'b0;
        i_data    = '0;
        force_tp1 = 1'b0;
        cyc       = 0;
        modelReset();
        for (int i = 0; i < 20; i++) begin
            vecs[i].valid      = (i < 8);
            vecs[i].data       = (i < 8) ? rowWord(i) : {DW{1'b0}};
            vecs[i].exp_ready  = 1'b1;
            vecs[i].exp_tp0_en = (i < 8);
            vecs[i].exp_tp1_en = 1'b0;
            vecs[i].exp_en     = (i >= 10 && i <= 17);
            vecs[i].exp_data   = (i >= 10 && i <= 17) ? colWord(i - 10) : {DW{1'b0}};
        end
        repeat (2) @(posedge clk);

        $display("[TB] single block R0..R7");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data);
            checkOutput("tbl_ready", o_ready, vecs[i].exp_ready);
            checkOutput("tbl_tp0_en", o_tp0_en, vecs[i].exp_tp0_en);
            checkOutput("tbl_tp1_en", o_tp1_en, vecs[i].exp_tp1_en);
            checkOutput("tbl_o_en", o_en, vecs[i].exp_en);
            checkOutput("tbl_o_data", o_data, vecs[i].exp_data);
        end
        applyStimulus(1'b0, '0);
        checkOutput("tbl_blk_cnt", o_blk_cnt, 1);
        checkOutput("tbl_latency", first_en_cyc - first_acc_cyc, 10);

        $display("[TB] four streamed blocks");
        doReset();
        runValid(1'b1, 32);
        runValid(1'b0, 12);
        checkOutput("stream_blk_cnt", o_blk_cnt, 4);
        checkOutput("stream_en_cycles", en_cycles, 32);
        checkOutput("stream_en_span", last_en_cyc - first_en_cyc + 1, 32);
        checkOutput("stream_banks", done_bits, 4'b0101);

        $display("[TB] gap inside block A");
        doReset();
        runValid(1'b1, 5);
        runValid(1'b0, 3);
        runValid(1'b1, 3);
        runValid(1'b1, 8);
        runValid(1'b0, 14);
        checkOutput("gap_first_en", first_en_cyc - first_done_cyc, 3);
        checkOutput("gap_blk_cnt", o_blk_cnt, 2);

        $display("[TB] blocks A, B and one row of C");
        doReset();
        runValid(1'b1, 17);
        runValid(1'b0, 12);
        checkOutput("abc_blk_cnt", o_blk_cnt, 2);
        checkOutput("abc_rows", n_acc, 17);

        $display("[TB] reset mid-block");
        doReset();
        runValid(1'b1, 5);
        doReset();
        runValid(1'b1, 8);
        runValid(1'b0, 12);
        checkOutput("midrst_blk_cnt", o_blk_cnt, 1);
        checkOutput("midrst_latency", first_en_cyc - first_acc_cyc, 10);
        checkOutput("midrst_bank0", done_bits, 0);

        $display("[TB] randomized traffic");
        doReset();
        foreach (vecs[s]) begin
            if (s < 5) begin
                int p;
                p = (s == 0) ? 100 : (s == 1) ? 80 : (s == 2) ? 50 : (s == 3) ? 25 : 95;
                for (int i = 0; i < 300; i++) begin
                    applyStimulus(($urandom_range(0, 99) < p) ? 1'b1 : 1'b0,
                                  {$urandom, $urandom, $urandom});
                end
            end
        end
        runValid(1'b0, 14);
        checkOutput("rand_blk_cnt", o_blk_cnt, blocks_done % 65536);
        checkOutput("no_corrupt", g_bank[0].corrupt + g_bank[1].corrupt, 0);

        $display("[TB] forced bank-1 valid outside its window");
        doReset();
        runValid(1'b0, 2);
        @(negedge clk);
        force_tp1 = 1'b1;
        @(negedge clk);
        force_tp1 = 1'b0;
        #1;
        checkOutput("err_set", o_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("err_sticky", o_err, 1'b1);
        end
        doReset();
        runValid(1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
